// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generation and detection blocks.
// Contents:
//   PWM_CNT_W_DEFAULT - default width of the high/low counts and the phase counter
//   pwm_state_e       - phase state encoding (IDLE/HIGH/LOW), common to both blocks
package pwm_pkg;

  localparam int unsigned PWM_CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_generation_if.sv
// Register-file side bundle of the PWM generator.
// master (register file): drives enable, load, high_count, low_count;
//                         receives pwm_out, period_intr, pending.
// slave  (generator)    : the reverse directions.
interface pwm_generation_if
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W_DEFAULT
);

  logic             enable;
  logic             load;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] low_count;
  logic             pwm_out;
  logic             period_intr;
  logic             pending;

  modport master (
    output enable, load, high_count, low_count,
    input  pwm_out, period_intr, pending
  );

  modport slave (
    input  enable, load, high_count, low_count,
    output pwm_out, period_intr, pending
  );

endinterface

// File: rtl/pwm_shadow_regs.sv
// Double-buffered high/low count registers for the PWM generator.
// A load strobe captures the requested counts into the pending pair and
// raises the pending flag; a period boundary moves a waiting pending pair
// into the active pair. A load landing on a boundary cycle is held for the
// following boundary.
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   load_i         - capture strobe for high_count_i/low_count_i
//   high_count_i   - requested high time
//   low_count_i    - requested low time
//   boundary_i     - the generator is starting a new period this cycle
//   eff_high_o     - high time the period starting at this boundary will use
//   eff_low_o      - low time the period starting at this boundary will use
//   act_low_o      - low time of the period currently running
//   pending_o      - a loaded pair is waiting for the next boundary
module pwm_shadow_regs
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] high_count_i,
  input  logic [CNT_W-1:0] low_count_i,
  input  logic             boundary_i,
  output logic [CNT_W-1:0] eff_high_o,
  output logic [CNT_W-1:0] eff_low_o,
  output logic [CNT_W-1:0] act_low_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] pend_h_q, pend_l_q;
  logic [CNT_W-1:0] act_h_q,  act_l_q;
  logic             pending_q;

  // Values seen at a boundary already include the pending transfer.
  assign eff_high_o = pending_q ? pend_h_q : act_h_q;
  assign eff_low_o  = pending_q ? pend_l_q : act_l_q;
  assign act_low_o  = act_l_q;
  assign pending_o  = pending_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_h_q  <= '0;
      pend_l_q  <= '0;
      act_h_q   <= '0;
      act_l_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (boundary_i && pending_q) begin
        act_h_q   <= pend_h_q;
        act_l_q   <= pend_l_q;
        pending_q <= 1'b0;
      end
      // The transfer above reads the old pending pair, so a same-cycle load
      // survives as the next pending value and re-arms the flag.
      if (load_i) begin
        pend_h_q  <= high_count_i;
        pend_l_q  <= low_count_i;
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_generation.sv
// PWM waveform generator driven from programmed high/low times (clk cycles).
// New counts are double-buffered (pwm_shadow_regs) and take effect only at a
// period boundary. period_intr pulses on the first output cycle of each period.
// Ports:
//   clk   - system clock, posedge
//   reset - synchronous active-low reset
//   bus   - pwm_generation_if.slave: enable, load, high_count, low_count in;
//           pwm_out, period_intr, pending out
// Build option: PWM_GEN_INVERT_EN - pwm_out pin drives the complement of the
//   internal waveform (1 in reset and IDLE); state machine and period_intr
//   are unaffected.
module pwm_generation
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  pwm_generation_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pwm_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pwm_q;
  logic             intr_q;

  logic             boundary;
  logic [CNT_W-1:0] eff_h, eff_l, act_l;

  pwm_shadow_regs #(
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .load_i       (bus.load),
    .high_count_i (bus.high_count),
    .low_count_i  (bus.low_count),
    .boundary_i   (boundary),
    .eff_high_o   (eff_h),
    .eff_low_o    (eff_l),
    .act_low_o    (act_l),
    .pending_o    (bus.pending)
  );

  // A boundary is where the next period starts: leaving IDLE, the end of a
  // HIGH phase with no LOW phase, or the end of a LOW phase.
  always_comb begin
    boundary = 1'b0;
    if (bus.enable) begin
      case (state_q)
        IDLE:    boundary = 1'b1;
        HIGH:    boundary = (cnt_q == '0) && (act_l == '0);
        LOW:     boundary = (cnt_q == '0);
        default: boundary = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else if (!bus.enable) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      intr_q <= 1'b0;
      case (state_q)
        HIGH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (act_l != '0) begin
            state_q <= LOW;
            cnt_q   <= act_l - CNT_ONE;
            pwm_q   <= 1'b0;
          end
        end
        LOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: ;
      endcase
      // Period start overrides the per-phase updates above.
      if (boundary) begin
        if (eff_h != '0) begin
          state_q <= HIGH;
          cnt_q   <= eff_h - CNT_ONE;
          pwm_q   <= 1'b1;
          intr_q  <= 1'b1;
        end else if (eff_l != '0) begin
          state_q <= LOW;
          cnt_q   <= eff_l - CNT_ONE;
          pwm_q   <= 1'b0;
          intr_q  <= 1'b1;
        end else begin
          state_q <= IDLE;
          cnt_q   <= '0;
          pwm_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.period_intr = intr_q;

`ifdef PWM_GEN_INVERT_EN
  assign bus.pwm_out = ~pwm_q;
`else
  assign bus.pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_generation.sv
// Self-checking bench for pwm_generation: directed scenarios followed by
// random stimulus, every cycle compared against a period-level model.
module tb_pwm_generation;

  localparam int unsigned CNT_W = 32;
`ifdef PWM_GEN_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk;
  logic reset;

  pwm_generation_if #(.CNT_W(CNT_W)) bus ();

  pwm_generation #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Period-level reference: a running period is (cur_h, cur_l) with the
  // output cycle index pos; output is high for pos < cur_h.
  bit              m_run, m_pend;
  longint unsigned m_cur_h, m_cur_l, m_pos;
  longint unsigned m_ph, m_pl, m_ah, m_al;

  task automatic model_update(input logic rst, input logic en, input logic ld,
                              input int unsigned h, input int unsigned l);
    longint unsigned eh, el;
    if (!rst) begin
      m_run = 0; m_pend = 0; m_pos = 0; m_cur_h = 0; m_cur_l = 0;
      m_ph = 0; m_pl = 0; m_ah = 0; m_al = 0;
    end else begin
      if (!en) begin
        m_run = 0;
      end else if (!m_run || (m_pos == m_cur_h + m_cur_l - 1)) begin
        eh = m_pend ? m_ph : m_ah;
        el = m_pend ? m_pl : m_al;
        if (m_pend) begin
          m_ah = m_ph; m_al = m_pl; m_pend = 0;
        end
        if (eh + el != 0) begin
          m_run = 1; m_cur_h = eh; m_cur_l = el; m_pos = 0;
        end else begin
          m_run = 0;
        end
      end else begin
        m_pos++;
      end
      if (ld) begin
        m_ph = h; m_pl = l; m_pend = 1;
      end
    end
  endtask

  function automatic bit at_last_cycle();
    return m_run && (m_pos == m_cur_h + m_cur_l - 1);
  endfunction

  task automatic step(input logic rst, input logic en, input logic ld,
                      input int unsigned h, input int unsigned l);
    logic exp_out, exp_intr;
    reset          = rst;
    bus.enable     = en;
    bus.load       = ld;
    bus.high_count = h;
    bus.low_count  = l;
    @(posedge clk);
    model_update(rst, en, ld, h, l);
    #1;
    exp_out  = m_run && (m_pos < m_cur_h);
    exp_intr = m_run && (m_pos == 0);
    check("pwm_out", 64'(bus.pwm_out), 64'(exp_out ^ INV));
    check("period_intr", 64'(bus.period_intr), 64'(exp_intr));
    check("pending", 64'(bus.pending), 64'(m_pend));
  endtask

  logic [7:0] pat;

  initial begin
    reset = 1'b0; bus.enable = 1'b0; bus.load = 1'b0;
    bus.high_count = '0; bus.low_count = '0;
    pat = 8'b0000_0111;

    // 1. reset held with enable/load active, then release with nothing loaded
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 7, 7);
    check("rst_pwm", 64'(bus.pwm_out), 64'(INV));
    check("rst_intr", 64'(bus.period_intr), 64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("idle_pwm", 64'(bus.pwm_out), 64'(INV));

    // 2. basic 3/5 waveform
    step(1'b1, 1'b0, 1'b1, 3, 5);
    check("load_pending", 64'(bus.pending), 64'd1);
    for (int k = 0; k < 24; k++) begin
      step(1'b1, 1'b1, 1'b0, 0, 0);
      check("pat_pwm", 64'(bus.pwm_out), 64'(pat[k % 8] ^ INV));
      check("pat_intr", 64'(bus.period_intr), 64'((k % 8) == 0));
      if (k == 0) check("pat_pending", 64'(bus.pending), 64'd0);
    end

    // 3. buffered update loaded mid-HIGH
    while (!(m_run && m_pos == 0)) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 2, 2);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b0, 0, 0);

    // 4. load on the boundary cycle: applied one period later
    for (int k = 0; k < 8 && !at_last_cycle(); k++) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 1, 3);
    check("bnd_pending", 64'(bus.pending), 64'd1);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 1'b0, 0, 0);

    // 5. extremes
    step(1'b1, 1'b1, 1'b1, 0, 4);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 4, 0);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 0, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 0, 0);
    check("zero_idle_pwm", 64'(bus.pwm_out), 64'(INV));
    check("zero_idle_intr", 64'(bus.period_intr), 64'd0);

    // 6. disable mid-HIGH, re-enable, then reset mid-LOW
    step(1'b1, 1'b1, 1'b1, 10, 3);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 0, 0);
    while (!(m_run && m_pos == 1)) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    check("dis_pwm", 64'(bus.pwm_out), 64'(INV));
    step(1'b1, 1'b1, 1'b0, 0, 0);
    check("reen_intr", 64'(bus.period_intr), 64'd1);
    check("reen_pwm", 64'(bus.pwm_out), 64'(1'b1 ^ INV));
    for (int k = 0; k < 11; k++) step(1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 5, 5);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    check("rst_low_pending", 64'(bus.pending), 64'd0);
    check("rst_low_pwm", 64'(bus.pwm_out), 64'(INV));
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 0, 0);

    // random stimulus
    for (int k = 0; k < 4000; k++) begin
      step(logic'($urandom_range(0, 199) != 0),
           logic'($urandom_range(0, 49) != 0),
           logic'($urandom_range(0, 9) == 0),
           $urandom_range(0, 6), $urandom_range(0, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
